// File: rtl/sar_search_if.sv
// Comparator-side bundle for sar_search: start request, trial value out, verdict in, result out.
// The hold input only exists when SAR_CMP_HOLD_EN is defined.
interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_gt;
`ifdef SAR_CMP_HOLD_EN
    logic             hold;
`endif
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output cmp_gt,
`ifdef SAR_CMP_HOLD_EN
        output hold,
`endif
        input  guess,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  cmp_gt,
`ifdef SAR_CMP_HOLD_EN
        input  hold,
`endif
        output guess,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: binary-searches a target seen only through cmp_gt (guess > target).
// Define SAR_CMP_HOLD_EN to add a hold input that stalls the search for slow comparators.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    sar_search_if.slave sar
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] guess_q,  guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] trial;
    logic             hold_req;

`ifdef SAR_CMP_HOLD_EN
    assign hold_req = sar.hold;
`else
    assign hold_req = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        trial    = guess_q;

        case (state_q)
            IDLE: begin
                guess_d = '0;
                busy_d  = 1'b0;
                if (sar.start) begin
                    guess_d = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = SEARCH;
                end
            end

            SEARCH: begin
                if (!hold_req) begin
                    // Resolve the current bit from the verdict, then arm the next lower bit.
                    if (sar.cmp_gt) begin
                        trial[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        trial[idx_q - 1'b1] = 1'b1;
                        idx_d               = idx_q - 1'b1;
                    end else begin
                        result_d = trial;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                    guess_d = trial;
                end
            end

            DONE: begin
                guess_d = '0;
                busy_d  = 1'b0;
                idx_d   = IW'(WIDTH - 1);
                state_d = IDLE;
            end

            default: begin
                guess_d = '0;
                busy_d  = 1'b0;
                idx_d   = IW'(WIDTH - 1);
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= IW'(WIDTH - 1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sar.guess  = guess_q;
    assign sar.busy   = busy_q;
    assign sar.done   = done_q;
    assign sar.result = result_q;
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: an ideal comparator model plus a scoreboard of expected guesses/results.
// Build with SAR_CMP_HOLD_EN defined to also exercise the hold input.
module tb_sar_search;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] tgt;

    int n_cmp;
    int n_err;
    int exp_q[$];
    int exp_held;

    sar_search_if #(.WIDTH(W)) bus ();

    sar_search #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .sar (bus.slave)
    );

    // Ideal combinational comparator: A = guess, B = target.
    assign bus.cmp_gt = (bus.guess > tgt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference binary search: push every trial value, then the final result.
    task automatic push_expected(input int target);
        int g;
        int trial;
        g = 0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = g | (1 << b);
            exp_q.push_back(trial);
            if (!(trial > target)) g = trial;
        end
        exp_q.push_back(g);
    endtask

    task automatic pop_expected(output int v);
        check("sb_nonempty", exp_q.size() != 0, 1);
        v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    endtask

    // start_step / hold_step are search-cycle indices (-1 = never); start_done re-asserts start during DONE.
    task automatic run_search(input int target, input int start_step, input bit start_done,
                              input int hold_step, input int hold_len);
        int eg;
        int er;
        tgt = target[W-1:0];
        push_expected(target);
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            bus.start = (i == start_step);
            pop_expected(eg);
            if (i == hold_step) begin
                for (int h = 0; h < hold_len; h++) begin
`ifdef SAR_CMP_HOLD_EN
                    bus.hold = 1'b1;
`endif
                    check("held_guess", bus.guess, eg);
                    check("held_busy", bus.busy, 1);
                    check("held_done", bus.done, 0);
                    tick();
                end
`ifdef SAR_CMP_HOLD_EN
                bus.hold = 1'b0;
`endif
            end
            check("guess", bus.guess, eg);
            check("busy", bus.busy, 1);
            check("done_low", bus.done, 0);
            check("result_held", bus.result, exp_held);
            tick();
        end
        bus.start = start_done;
        pop_expected(er);
        check("done_pulse", bus.done, 1);
        check("busy_in_done", bus.busy, 0);
        check("result", bus.result, er);
        check("guess_final", bus.guess, er);
        exp_held = er;
        tick();
        bus.start = 1'b0;
        check("done_once", bus.done, 0);
        check("busy_idle", bus.busy, 0);
        check("guess_idle", bus.guess, 0);
        check("result_keep", bus.result, exp_held);
    endtask

    task automatic run_reset(input int target, input int rst_step);
        int eg;
        tgt = target[W-1:0];
        push_expected(target);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= rst_step; i++) begin
            pop_expected(eg);
            check("pre_rst_guess", bus.guess, eg);
            if (i < rst_step) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_held = 0;
        check("rst_guess", bus.guess, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        tick();
        check("post_rst_idle_guess", bus.guess, 0);
        check("post_rst_idle_busy", bus.busy, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_held = 0;
        rst      = 1'b1;
        tgt      = '0;
        bus.start = 1'b0;
`ifdef SAR_CMP_HOLD_EN
        bus.hold = 1'b0;
`endif
        tick();
        tick();
        check("reset_guess", bus.guess, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        rst = 1'b0;
        tick();
        check("idle_guess", bus.guess, 0);

        run_search(0, -1, 1'b0, -1, 0);
        run_search(15, -1, 1'b0, -1, 0);
        run_search(9, -1, 1'b0, -1, 0);
        run_search(6, -1, 1'b0, -1, 0);
        run_search(11, 1, 1'b1, -1, 0);
        run_reset(13, 2);
        run_search(13, -1, 1'b0, -1, 0);
`ifdef SAR_CMP_HOLD_EN
        run_search(5, -1, 1'b0, 1, 2);
        run_search(10, 0, 1'b1, 3, 1);
`endif
        for (int t = 0; t < (1 << W); t++) begin
            run_search(t, -1, 1'b0, -1, 0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
